// File: rtl/bist_pkg.sv
// Shared definitions for the March C- BIST controller: element indices,
// operation and direction encodings, FSM states and the march table.
package bist_pkg;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    localparam logic OP_R = 1'b0;
    localparam logic OP_W = 1'b1;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // One march element: address order, first op/background, second
    // op/background, and whether the second op exists at all.
    typedef struct packed {
        logic dir;
        logic op0;
        logic bg0;
        logic op1;
        logic bg1;
        logic twoOp;
    } march_entry_t;

    // The first three elements walk upwards, the last three downwards.
    function automatic logic marchDir(input logic [2:0] elem);
        return (elem >= E3) ? DIR_DN : DIR_UP;
    endfunction

    function automatic march_entry_t marchTable(input logic [2:0] elem);
        march_entry_t e;
        case (elem)
            E0:      e = '{marchDir(E0), OP_W, 1'b0, OP_W, 1'b0, 1'b0};
            E1:      e = '{marchDir(E1), OP_R, 1'b0, OP_W, 1'b1, 1'b1};
            E2:      e = '{marchDir(E2), OP_R, 1'b1, OP_W, 1'b0, 1'b1};
            E3:      e = '{marchDir(E3), OP_R, 1'b0, OP_W, 1'b1, 1'b1};
            E4:      e = '{marchDir(E4), OP_R, 1'b1, OP_W, 1'b0, 1'b1};
            E5:      e = '{marchDir(E5), OP_R, 1'b0, OP_R, 1'b0, 1'b0};
            default: e = '{DIR_UP, OP_W, 1'b0, OP_W, 1'b0, 1'b0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter for the march sequencer. Loads 0 or all-ones at
// element boundaries and flags the last address in the current direction.
module bist_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load0_i,
    input  logic              loadMax_i,
    input  logic              en_i,
    input  logic              dirDn_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tc_o
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] addr_q, addr_d;

    // Loads take priority over stepping; the counter holds when idle.
    always_comb begin
        addr_d = addr_q;
        if (load0_i) begin
            addr_d = '0;
        end else if (loadMax_i) begin
            addr_d = '1;
        end else if (en_i) begin
            addr_d = dirDn_i ? (addr_q - ONE) : (addr_q + ONE);
        end
    end

    // Address register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign tc_o   = dirDn_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer for a single-port synchronous SRAM. Issues one
// registered memory operation per cycle, compares read data one cycle after
// the read strobe and records the first failing address and element.
module march_bist_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    import bist_pkg::*;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic              memWe_q, memWe_d;
    logic              memRe_q, memRe_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [2:0]        opElem_q, opElem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] failAddr_q, failAddr_d;
    logic [2:0]        failElem_q, failElem_d;

    logic              cmpValid_q;
    logic [DATA_W-1:0] cmpExp_q;
    logic [ADDR_W-1:0] cmpAddr_q;
    logic [2:0]        cmpElem_q;

    march_entry_t      tbl;
    logic              curOp;
    logic              curBg;
    logic              agLoad0, agLoadMax, agEn;
    logic [ADDR_W-1:0] agAddr;
    logic              agTc;

    assign tbl = marchTable(elem_q);

    bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load0_i   (agLoad0),
        .loadMax_i (agLoadMax),
        .en_i      (agEn),
        .dirDn_i   (tbl.dir),
        .addr_o    (agAddr),
        .tc_o      (agTc)
    );

    // Next-state logic: op issue, element sequencing, compare and status.
    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        phase_d    = phase_q;
        memAddr_d  = '0;
        memWe_d    = 1'b0;
        memRe_d    = 1'b0;
        memWdata_d = '0;
        opElem_d   = '0;
        busy_d     = busy_q;
        done_d     = done_q;
        fail_d     = fail_q;
        failAddr_d = failAddr_q;
        failElem_d = failElem_q;
        agLoad0    = 1'b0;
        agLoadMax  = 1'b0;
        agEn       = 1'b0;
        curOp      = phase_q ? tbl.op1 : tbl.op0;
        curBg      = phase_q ? tbl.bg1 : tbl.bg0;

        if (cmpValid_q && (mem_rdata != cmpExp_q) && !fail_q) begin
            fail_d     = 1'b1;
            failAddr_d = cmpAddr_q;
            failElem_d = cmpElem_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    elem_d     = E0;
                    phase_d    = 1'b0;
                    agLoad0    = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    failAddr_d = '0;
                    failElem_d = '0;
                end
            end
            ST_RUN: begin
                memAddr_d  = agAddr;
                memWe_d    = (curOp == OP_W);
                memRe_d    = (curOp == OP_R);
                memWdata_d = {DATA_W{curBg}};
                opElem_d   = elem_q;
                if (!tbl.twoOp || phase_q) begin
                    phase_d = 1'b0;
                    if (agTc) begin
                        if (elem_q == E5) begin
                            state_d = ST_DRAIN;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            if (marchDir(elem_q + 3'd1) == DIR_DN) begin
                                agLoadMax = 1'b1;
                            end else begin
                                agLoad0 = 1'b1;
                            end
                        end
                    end else begin
                        agEn = 1'b1;
                    end
                end else begin
                    phase_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!memRe_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, strobe, compare-pipeline and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            elem_q     <= '0;
            phase_q    <= 1'b0;
            memAddr_q  <= '0;
            memWe_q    <= 1'b0;
            memRe_q    <= 1'b0;
            memWdata_q <= '0;
            opElem_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            failAddr_q <= '0;
            failElem_q <= '0;
            cmpValid_q <= 1'b0;
            cmpExp_q   <= '0;
            cmpAddr_q  <= '0;
            cmpElem_q  <= '0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            phase_q    <= phase_d;
            memAddr_q  <= memAddr_d;
            memWe_q    <= memWe_d;
            memRe_q    <= memRe_d;
            memWdata_q <= memWdata_d;
            opElem_q   <= opElem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            failAddr_q <= failAddr_d;
            failElem_q <= failElem_d;
            cmpValid_q <= memRe_q;
            cmpExp_q   <= memWdata_q;
            cmpAddr_q  <= memAddr_q;
            cmpElem_q  <= opElem_q;
        end
    end

    assign mem_addr  = memAddr_q;
    assign mem_we    = memWe_q;
    assign mem_re    = memRe_q;
    assign mem_wdata = memWdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = failAddr_q;
    assign fail_elem = failElem_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Self-checking bench for march_bist_ctrl: a 16x8 SRAM model with
// per-address stuck-at masks, an op scoreboard fed from an independent
// March C- model, and per-scenario run result checks.
module tb_march_bist_ctrl;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int N         = 16;
    localparam int RUN_EDGES = 162;
    localparam int MAX_EDGES = 400;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;

    typedef struct packed {
        logic        we;
        logic        re;
        logic [3:0]  addr;
        logic [7:0]  data;
    } op_t;

    typedef struct packed {
        logic        fail;
        logic [3:0]  addr;
        logic [2:0]  elem;
    } res_t;

    op_t  opQ[$];
    res_t resQ[$];
    int   checks = 0;
    int   errors = 0;

    logic [DATA_W-1:0] mem   [N];
    logic [DATA_W-1:0] sa0Mask [N];
    logic [DATA_W-1:0] sa1Mask [N];

    always #5 clk = ~clk;

    march_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    // Synchronous SRAM with stuck-at faults applied on the read path.
    initial begin
        mem_rdata = '0;
        for (int i = 0; i < N; i++) begin
            mem[i]     = 8'($urandom);
            sa0Mask[i] = '0;
            sa1Mask[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= (mem[mem_addr] & ~sa0Mask[mem_addr]) | sa1Mask[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Scoreboard consumer: every strobe cycle must match the next expected op.
    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            op_t got;
            op_t exp;
            got = '{mem_we, mem_re, mem_addr, (mem_we ? mem_wdata : 8'h00)};
            checks++;
            if (opQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL op_unexpected: got we=%0b re=%0b addr=%0d, required no op", mem_we, mem_re, mem_addr);
            end else begin
                exp = opQ.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("[TB] FAIL op_seq: got we=%0b re=%0b addr=%0d data=%h, required we=%0b re=%0b addr=%0d data=%h",
                             got.we, got.re, got.addr, got.data, exp.we, exp.re, exp.addr, exp.data);
                end
            end
        end
    end

    // Reference March C- sequence plus the expected run outcome.
    task automatic pushRun(input logic expFail, input logic [3:0] expAddr, input logic [2:0] expElem);
        logic [5:0] wbgBits;
        logic [3:0] a;
        wbgBits = 6'b001010;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = (e >= 3) ? 4'(N - 1 - k) : 4'(k);
                if (e != 0) opQ.push_back('{1'b0, 1'b1, a, 8'h00});
                if (e != 5) opQ.push_back('{1'b1, 1'b0, a, (wbgBits[e] ? 8'hFF : 8'h00)});
            end
        end
        resQ.push_back('{expFail, expAddr, expElem});
    endtask

    task automatic pulseStart(input logic expFail, input logic [3:0] expAddr, input logic [2:0] expElem);
        @(negedge clk);
        pushRun(expFail, expAddr, expElem);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Bounded wait for done; optionally re-pulses start mid-run.
    task automatic waitDone(input int repulseAt, output int edges, output int busyLow);
        edges   = 0;
        busyLow = 0;
        while (edges < MAX_EDGES) begin
            @(posedge clk);
            #1;
            edges++;
            start = 1'b0;
            if (done) break;
            if (!busy) busyLow++;
            if (edges == repulseAt) start = 1'b1;
        end
        if (!done) edges = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes: got %b, required 00", {mem_we, mem_re}); end
        checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %0d, required 0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("[TB] FAIL reset_wdata: got %h, required 00", mem_wdata); end
        checks++; if ({busy, done, fail} !== 3'b000) begin errors++; $display("[TB] FAIL reset_status: got %b, required 000", {busy, done, fail}); end
        checks++; if ({fail_addr, fail_elem} !== 7'd0) begin errors++; $display("[TB] FAIL reset_fail_info: got %h, required 0", {fail_addr, fail_elem}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Common end-of-run checks are written out in each scenario task.
    task automatic test_fault_free();
        int   edges, busyLow;
        res_t exp, got;
        pulseStart(1'b0, 4'd0, 3'd0);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ff_busy_at_start: got %b, required 1", busy); end
        waitDone(0, edges, busyLow);
        checks++; if (edges != RUN_EDGES) begin errors++; $display("[TB] FAIL ff_done_edge: got %0d, required %0d", edges, RUN_EDGES); end
        checks++; if (busyLow != 0) begin errors++; $display("[TB] FAIL ff_busy_gap: got %0d low cycles, required 0", busyLow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ff_busy_at_done: got %b, required 0", busy); end
        checks++; if (opQ.size() != 0) begin errors++; $display("[TB] FAIL ff_ops_left: got %0d, required 0", opQ.size()); end
        exp = resQ.pop_front(); got = '{fail, fail_addr, fail_elem};
        checks++; if (got !== exp) begin errors++; $display("[TB] FAIL ff_result: got %h, required %h", got, exp); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ff_done_held: got %b, required 1", done); end
    endtask

    task automatic test_stuck_at0();
        int   edges, busyLow;
        res_t exp, got;
        sa0Mask[5] = 8'h08;
        pulseStart(1'b1, 4'd5, 3'd2);
        waitDone(0, edges, busyLow);
        checks++; if (edges != RUN_EDGES) begin errors++; $display("[TB] FAIL sa0_done_edge: got %0d, required %0d", edges, RUN_EDGES); end
        checks++; if (opQ.size() != 0) begin errors++; $display("[TB] FAIL sa0_ops_left: got %0d, required 0", opQ.size()); end
        exp = resQ.pop_front(); got = '{fail, fail_addr, fail_elem};
        checks++; if (got !== exp) begin errors++; $display("[TB] FAIL sa0_result: got %h, required %h", got, exp); end
        sa0Mask[5] = 8'h00;
    endtask

    task automatic test_stuck_at1_two_faults();
        int   edges, busyLow;
        res_t exp, got;
        sa1Mask[10] = 8'h01;
        sa1Mask[12] = 8'h01;
        pulseStart(1'b1, 4'd10, 3'd1);
        checks++; if ({fail, done} !== 2'b00) begin errors++; $display("[TB] FAIL sa1_clear_at_start: got %b, required 00", {fail, done}); end
        waitDone(0, edges, busyLow);
        checks++; if (edges != RUN_EDGES) begin errors++; $display("[TB] FAIL sa1_done_edge: got %0d, required %0d", edges, RUN_EDGES); end
        exp = resQ.pop_front(); got = '{fail, fail_addr, fail_elem};
        checks++; if (got !== exp) begin errors++; $display("[TB] FAIL sa1_result: got %h, required %h", got, exp); end
        sa1Mask[10] = 8'h00;
        sa1Mask[12] = 8'h00;
    endtask

    task automatic test_restart_ignored();
        int   edges, busyLow;
        res_t exp, got;
        pulseStart(1'b0, 4'd0, 3'd0);
        waitDone(50, edges, busyLow);
        checks++; if (edges != RUN_EDGES) begin errors++; $display("[TB] FAIL repulse_done_edge: got %0d, required %0d", edges, RUN_EDGES); end
        checks++; if (busyLow != 0) begin errors++; $display("[TB] FAIL repulse_busy_gap: got %0d, required 0", busyLow); end
        checks++; if (opQ.size() != 0) begin errors++; $display("[TB] FAIL repulse_ops_left: got %0d, required 0", opQ.size()); end
        exp = resQ.pop_front(); got = '{fail, fail_addr, fail_elem};
        checks++; if (got !== exp) begin errors++; $display("[TB] FAIL repulse_result: got %h, required %h", got, exp); end
    endtask

    task automatic test_reset_midrun();
        int   edges, busyLow;
        res_t exp, got;
        sa1Mask[2] = 8'h80;
        pulseStart(1'b1, 4'd2, 3'd1);
        repeat (39) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({mem_we, mem_re, mem_addr, mem_wdata} !== '0) begin errors++; $display("[TB] FAIL midrst_mem_port: got %h, required 0", {mem_we, mem_re, mem_addr, mem_wdata}); end
        checks++; if ({busy, done, fail, fail_addr, fail_elem} !== '0) begin errors++; $display("[TB] FAIL midrst_status: got %h, required 0", {busy, done, fail, fail_addr, fail_elem}); end
        @(negedge clk);
        rst = 1'b0;
        opQ.delete();
        resQ.delete();
        sa1Mask[2] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy, done, mem_we, mem_re} !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_idle: got %b, required 0000", {busy, done, mem_we, mem_re}); end
        pulseStart(1'b0, 4'd0, 3'd0);
        waitDone(0, edges, busyLow);
        checks++; if (edges != RUN_EDGES) begin errors++; $display("[TB] FAIL midrst_rerun_edge: got %0d, required %0d", edges, RUN_EDGES); end
        exp = resQ.pop_front(); got = '{fail, fail_addr, fail_elem};
        checks++; if (got !== exp) begin errors++; $display("[TB] FAIL midrst_rerun_result: got %h, required %h", got, exp); end
    endtask

    task automatic test_fail_clears();
        int   edges, busyLow;
        res_t exp, got;
        sa0Mask[15] = 8'h40;
        pulseStart(1'b1, 4'd15, 3'd2);
        waitDone(0, edges, busyLow);
        exp = resQ.pop_front(); got = '{fail, fail_addr, fail_elem};
        checks++; if (got !== exp) begin errors++; $display("[TB] FAIL fclr_faulty_result: got %h, required %h", got, exp); end
        sa0Mask[15] = 8'h00;
        pulseStart(1'b0, 4'd0, 3'd0);
        checks++; if ({fail, fail_addr, fail_elem, done, busy} !== 10'b1) begin errors++; $display("[TB] FAIL fclr_at_start: got %h, required 001", {fail, fail_addr, fail_elem, done, busy}); end
        waitDone(0, edges, busyLow);
        checks++; if (edges != RUN_EDGES) begin errors++; $display("[TB] FAIL fclr_done_edge: got %0d, required %0d", edges, RUN_EDGES); end
        exp = resQ.pop_front(); got = '{fail, fail_addr, fail_elem};
        checks++; if (got !== exp) begin errors++; $display("[TB] FAIL fclr_clean_result: got %h, required %h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_at0();
        test_stuck_at1_two_faults();
        test_restart_ignored();
        test_reset_midrun();
        test_fail_clears();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
